bin2gray_counter: RTL

- Binary up/down counter with a registered Gray-coded output.
- Produces Gray-coded pointers and sequence codes for consumers that decode Gray back to binary, for example clock-domain-crossing FIFO pointers.
- Keeps the binary state and its Gray image in lock-step.
- Provides a one-step-ahead Gray lookahead for pointer comparison logic.

---
 rtl/bin2gray_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/bin2gray_counter.sv
// ---------------------------------------------------------------------------
// bin2gray_counter
//
// Binary up/down counter with a registered Gray-coded image of the count.
// The binary state and its Gray code are registered on the same edge.
// Both are derived from the same next-state value, so they can never skew.
// A combinational one-step lookahead (GRAY_NXT) lets pointer-compare logic
// see where the counter would go on the next EN step.
//
// Parameters:
//   NUM_PIN   - MSB index; counter and code width is NUM_PIN+1 bits
//   WRAP_MODE - 1: wrap at terminal count, 0: saturate (hold) at terminal count
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RST      in   synchronous active-high reset (highest priority)
//   EN       in   count-step request
//   UP       in   direction: 1 = increment, 0 = decrement
//   LOAD     in   synchronous load strobe (beats EN)
//   LOAD_BIN in   binary value to load
//   BIN      out  registered binary count
//   GRAY     out  registered Gray code of BIN
//   GRAY_NXT out  combinational Gray code of the next EN step in direction UP
//   WRAP     out  registered one-cycle pulse on a terminal-count crossing
// ---------------------------------------------------------------------------
module bin2gray_counter #(
  parameter int NUM_PIN   = 3,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               UP,
  input  logic               LOAD,
  input  logic [NUM_PIN:0]   LOAD_BIN,
  output logic [NUM_PIN:0]   BIN,
  output logic [NUM_PIN:0]   GRAY,
  output logic [NUM_PIN:0]   GRAY_NXT,
  output logic               WRAP
);

  localparam int W = NUM_PIN + 1;
  localparam logic [W-1:0] MaxVal = '1;
  localparam logic [W-1:0] MinVal = '0;

  logic [W-1:0] stepBin;
  logic         stepWrap;
  logic [W-1:0] nextBin;
  logic [W-1:0] nextGray;
  logic         nextWrap;

  function automatic logic [W-1:0] toGray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Value one EN step would produce from the current count in the current
  // direction. At the terminal count it either wraps (and flags it) or
  // stays put when saturating, which makes GRAY_NXT equal GRAY there.
  always_comb begin
    stepBin  = BIN;
    stepWrap = 1'b0;
    if (UP) begin
      if (BIN == MaxVal) begin
        if (WRAP_MODE) begin
          stepBin  = MinVal;
          stepWrap = 1'b1;
        end
      end else begin
        stepBin = BIN + 1'b1;
      end
    end else begin
      if (BIN == MinVal) begin
        if (WRAP_MODE) begin
          stepBin  = MaxVal;
          stepWrap = 1'b1;
        end
      end else begin
        stepBin = BIN - 1'b1;
      end
    end
  end

  assign GRAY_NXT = toGray(stepBin);

  // Next-state selection: LOAD beats EN, otherwise hold. WRAP is a pulse,
  // so every path other than a wrapping step drives it low.
  // The Gray image is taken from nextBin, never from the registered BIN,
  // so BIN and GRAY always update together.
  always_comb begin
    nextBin  = BIN;
    nextWrap = 1'b0;
    if (LOAD) begin
      nextBin = LOAD_BIN;
    end else if (EN) begin
      nextBin  = stepBin;
      nextWrap = stepWrap;
    end
    nextGray = toGray(nextBin);
  end

  // State register; synchronous reset discards any in-flight LOAD or EN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BIN  <= '0;
      GRAY <= '0;
      WRAP <= 1'b0;
    end else begin
      BIN  <= nextBin;
      GRAY <= nextGray;
      WRAP <= nextWrap;
    end
  end

endmodule
